// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, status codes and fetch FSM encoding
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
                         I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                         I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
  typedef enum logic [2:0] {IDLE, REQ, OUT, WAIT, HALT} state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus
interface fetch_stage_if;
  logic        req;
  logic [63:0] addr;
  logic        rdy;
  logic [79:0] rdata;
  logic        err;
  modport master (output req, addr, input rdy, rdata, err);
  modport slave  (input req, addr, output rdy, rdata, err);
endinterface

// File: rtl/fetch_split.sv
// fetch_split: combinational split of a 10-byte bundle into Y86-64 fields
module fetch_split
  import y86_pkg::*;
(
  input  logic [79:0] bundle,
  input  logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [63:0] valp,
  output logic        instr_valid,
  output logic        need_regids,
  output logic        need_valc
);
  assign icode = bundle[7:4];
  assign ifun = bundle[3:0];
  assign need_regids = icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  assign need_valc = icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
  assign ra = need_regids ? bundle[15:12] : 4'hF;
  assign rb = need_regids ? bundle[11:8] : 4'hF;
  assign valc = !need_valc ? 64'd0 : need_regids ? bundle[79:16] : bundle[71:8];
  assign valp = pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'd0};
  assign instr_valid = icode <= I_POPQ &&
                       (ifun == 4'h0 || (icode == I_OPQ && ifun <= 4'h3) ||
                        ((icode == I_RRMOVQ || icode == I_JXX) && ifun <= 4'h6));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 SEQ fetch with PC register, imem handshake and registered decode
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] new_pc,
  input  logic        pc_load,
  fetch_stage_if.master imem,
  output logic        f_valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [63:0] valp,
  output logic [2:0]  stat
);
  state_t      state;
  logic [63:0] pc;
  logic [3:0]  s_icode, s_ifun, s_ra, s_rb;
  logic [63:0] s_valc, s_valp;
  logic        s_valid;
  logic [2:0]  s_stat;
  fetch_split u_split (
    .bundle(imem.rdata), .pc(pc), .icode(s_icode), .ifun(s_ifun), .ra(s_ra), .rb(s_rb),
    .valc(s_valc), .valp(s_valp), .instr_valid(s_valid), .need_regids(), .need_valc()
  );
  assign s_stat = imem.err ? S_ADR : !s_valid ? S_INS : s_icode == I_HALT ? S_HLT : S_AOK;
  assign imem.req = state == REQ;
  assign imem.addr = pc;
  // FSM, pc register and result capture on the accepted memory handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      f_valid <= 1'b0;
      icode <= '0;
      ifun <= '0;
      ra <= '0;
      rb <= '0;
      valc <= '0;
      valp <= '0;
      stat <= S_AOK;
    end else begin
      f_valid <= state == REQ && imem.rdy;
      case (state)
        IDLE: state <= REQ;
        REQ: if (imem.rdy) begin
          state <= OUT;
          icode <= s_icode;
          ifun <= s_ifun;
          ra <= s_ra;
          rb <= s_rb;
          valc <= s_valc;
          valp <= s_valp;
          stat <= s_stat;
        end
        OUT: state <= stat == S_AOK ? WAIT : HALT;
        WAIT: if (pc_load) begin
          state <= REQ;
          pc <= new_pc;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule
